// File: rtl/param_csa_pipe.sv
// Two-stage pipelined carry-select adder with valid/ready handshaking on both sides.
// Define CSA_SUB_EN to add the 'sub' input (a - b computed as a + ~b + 1).
module param_csa_pipe #(
  parameter int WIDTH = 32,
  parameter int BLOCK = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
`ifdef CSA_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             overflow
);

  // WIDTH must be a multiple of BLOCK and hold at least two blocks.
  localparam int NB = WIDTH / BLOCK;
  localparam int UW = WIDTH - BLOCK;

  logic [WIDTH-1:0] bEff;
  logic             cEff;

`ifdef CSA_SUB_EN
  assign bEff = sub ? ~b : b;
  assign cEff = sub ? 1'b1 : ci;
`else
  assign bEff = b;
  assign cEff = ci;
`endif

  logic             s1Valid;
  logic             s1Advance;
  logic             s2Advance;

  logic [BLOCK-1:0] lowSumD, lowSumQ;
  logic             lowCarryD, lowCarryQ;
  logic [UW-1:0]    sum0D, sum1D, sum0Q, sum1Q;
  logic [NB-2:0]    carry0D, carry1D, carry0Q, carry1Q;
  logic             ovf0D, ovf1D, ovf0Q, ovf1Q;
  logic [BLOCK:0]   blk0, blk1;

  logic [WIDTH-1:0] sumD;
  logic             coD;
  logic             ovfD;
  logic             carryChain;

  assign s2Advance = !out_valid || out_ready;
  assign s1Advance = !s1Valid || s2Advance;
  assign in_ready  = s1Advance;

  // Upper blocks precompute both carry-in outcomes so stage 2 only has to select.
  always_comb begin
    blk0    = '0;
    blk1    = '0;
    sum0D   = '0;
    sum1D   = '0;
    carry0D = '0;
    carry1D = '0;
    {lowCarryD, lowSumD} = {1'b0, a[BLOCK-1:0]} + {1'b0, bEff[BLOCK-1:0]}
                         + {{BLOCK{1'b0}}, cEff};
    for (int k = 1; k < NB; k++) begin
      blk0 = {1'b0, a[k*BLOCK +: BLOCK]} + {1'b0, bEff[k*BLOCK +: BLOCK]};
      blk1 = blk0 + {{BLOCK{1'b0}}, 1'b1};
      sum0D[(k-1)*BLOCK +: BLOCK] = blk0[BLOCK-1:0];
      sum1D[(k-1)*BLOCK +: BLOCK] = blk1[BLOCK-1:0];
      carry0D[k-1] = blk0[BLOCK];
      carry1D[k-1] = blk1[BLOCK];
    end
    ovf0D = (a[WIDTH-1] == bEff[WIDTH-1]) && (sum0D[UW-1] != a[WIDTH-1]);
    ovf1D = (a[WIDTH-1] == bEff[WIDTH-1]) && (sum1D[UW-1] != a[WIDTH-1]);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1Valid   <= 1'b0;
      lowSumQ   <= '0;
      lowCarryQ <= 1'b0;
      sum0Q     <= '0;
      sum1Q     <= '0;
      carry0Q   <= '0;
      carry1Q   <= '0;
      ovf0Q     <= 1'b0;
      ovf1Q     <= 1'b0;
    end else if (s1Advance) begin
      s1Valid <= in_valid;
      if (in_valid) begin
        lowSumQ   <= lowSumD;
        lowCarryQ <= lowCarryD;
        sum0Q     <= sum0D;
        sum1Q     <= sum1D;
        carry0Q   <= carry0D;
        carry1Q   <= carry1D;
        ovf0Q     <= ovf0D;
        ovf1Q     <= ovf1D;
      end
    end
  end

  // Ripple the block carries; the top block's overflow is chosen by its incoming carry.
  always_comb begin
    carryChain         = lowCarryQ;
    sumD               = '0;
    sumD[BLOCK-1:0]    = lowSumQ;
    ovfD               = ovf0Q;
    for (int k = 1; k < NB; k++) begin
      sumD[k*BLOCK +: BLOCK] = carryChain ? sum1Q[(k-1)*BLOCK +: BLOCK]
                                          : sum0Q[(k-1)*BLOCK +: BLOCK];
      if (k == NB - 1) begin
        ovfD = carryChain ? ovf1Q : ovf0Q;
      end
      carryChain = carryChain ? carry1Q[k-1] : carry0Q[k-1];
    end
    coD = carryChain;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      s         <= '0;
      co        <= 1'b0;
      overflow  <= 1'b0;
    end else if (s2Advance) begin
      out_valid <= s1Valid;
      if (s1Valid) begin
        s        <= sumD;
        co       <= coD;
        overflow <= ovfD;
      end
    end
  end

endmodule

// File: tb/tb_param_csa_pipe.sv
// Directed testbench for param_csa_pipe: a 32/8 instance for directed work and a 16/4 instance
// for a long random stream. Define CSA_SUB_EN to also exercise subtract mode.
module tb_param_csa_pipe;

  logic        clock = 1'b0;
  logic        reset;

  logic        in_valid, in_ready, ci, out_valid, out_ready, co, overflow;
  logic [31:0] a, b, s;
  logic        inValid16, inReady16, ci16, outValid16, outReady16, co16, overflow16;
  logic [15:0] a16, b16, s16;
`ifdef CSA_SUB_EN
  logic        sub, sub16;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  param_csa_pipe #(.WIDTH(32), .BLOCK(8)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ci(ci),
`ifdef CSA_SUB_EN
    .sub(sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .s(s), .co(co), .overflow(overflow)
  );

  param_csa_pipe #(.WIDTH(16), .BLOCK(4)) dut16 (
    .clock(clock), .reset(reset), .in_valid(inValid16), .in_ready(inReady16),
    .a(a16), .b(b16), .ci(ci16),
`ifdef CSA_SUB_EN
    .sub(sub16),
`endif
    .out_valid(outValid16), .out_ready(outReady16), .s(s16), .co(co16), .overflow(overflow16)
  );

  // Reference: full-width add, overflow from the carry into the MSB versus the carry out.
  task automatic model32(input logic [31:0] x, input logic [31:0] y, input logic c,
                         output logic [31:0] sum, output logic cout, output logic ovf);
    logic [32:0] full;
    logic [31:0] low;
    full = {1'b0, x} + {1'b0, y} + {32'd0, c};
    low  = {1'b0, x[30:0]} + {1'b0, y[30:0]} + {31'd0, c};
    sum  = full[31:0];
    cout = full[32];
    ovf  = low[31] ^ full[32];
  endtask

  task automatic model16(input logic [15:0] x, input logic [15:0] y, input logic c,
                         output logic [15:0] sum, output logic cout, output logic ovf);
    logic [16:0] full;
    logic [15:0] low;
    full = {1'b0, x} + {1'b0, y} + {16'd0, c};
    low  = {1'b0, x[14:0]} + {1'b0, y[14:0]} + {15'd0, c};
    sum  = full[15:0];
    cout = full[16];
    ovf  = low[15] ^ full[16];
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; ci = 1'b0;
    inValid16 = 1'b0; outReady16 = 1'b1; a16 = '0; b16 = '0; ci16 = 1'b0;
`ifdef CSA_SUB_EN
    sub = 1'b0; sub16 = 1'b0;
`endif
    #2;
    checks++;
    if ({out_valid, s, co, overflow} !== 35'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got v=%0b s=%h co=%0b ov=%0b expected all zero",
               out_valid, s, co, overflow);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_in_ready got %0b expected 1", in_ready);
    end
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL post_reset_in_ready got %0b expected 1", in_ready);
    end
    @(posedge clock); #1;
  endtask

  // Operands driven in cycle 0 appear on the outputs in cycle 2.
  task automatic test_vectors();
    logic [31:0] ta [6] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 32'h12345678,
                            32'h80000000, 32'hFFFFFFFF, 32'h00FF00FF};
    logic [31:0] tb [6] = '{32'h00000001, 32'h00000000, 32'h9ABCDEF0,
                            32'h80000000, 32'hFFFFFFFF, 32'h00010001};
    logic        tc [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] es [6] = '{32'h80000000, 32'h00000000, 32'hACF13568,
                            32'h00000000, 32'hFFFFFFFF, 32'h01000101};
    logic        ec [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic        eo [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      a = ta[i]; b = tb[i]; ci = tc[i]; in_valid = 1'b1; out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("[TB] FAIL vec%0d_in_ready got %0b expected 1", i, in_ready);
      end
      @(posedge clock); #1;
      in_valid = 1'b0; a = '0; b = '0; ci = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL vec%0d_early_valid got %0b expected 0", i, out_valid);
      end
      @(posedge clock); #1;
      checks++;
      if (out_valid !== 1'b1) begin
        errors++;
        $display("[TB] FAIL vec%0d_valid got %0b expected 1", i, out_valid);
      end
      checks++;
      if ({s, co, overflow} !== {es[i], ec[i], eo[i]}) begin
        errors++;
        $display("[TB] FAIL vec%0d_result got s=%h co=%0b ov=%0b expected s=%h co=%0b ov=%0b",
                 i, s, co, overflow, es[i], ec[i], eo[i]);
      end
      @(posedge clock); #1;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL vec%0d_drain got %0b expected 0", i, out_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] va [8], vb [8], xs [8];
    logic        vc [8], xc [8], xo [8];
    logic [31:0] prevS;
    logic        prevCo, prevOv, prevStall, expReady, fireIn, fireOut;
    int          sent, recv, occ, cyc;
    for (int i = 0; i < 8; i++) begin
      va[i] = 32'h1000_0000 * i + 32'(i) + 32'h7F00_0000;
      vb[i] = 32'h0F00_00FF + 32'(i) * 32'h0101_0101;
      vc[i] = i[0];
      model32(va[i], vb[i], vc[i], xs[i], xc[i], xo[i]);
    end
    sent = 0; recv = 0; occ = 0; cyc = 0; prevStall = 1'b0;
    prevS = '0; prevCo = 1'b0; prevOv = 1'b0;
    while (recv < 8 && cyc < 60) begin
      out_ready = !(cyc >= 3 && cyc < 7);
      if (sent < 8) begin
        in_valid = 1'b1; a = va[sent]; b = vb[sent]; ci = vc[sent];
      end else begin
        in_valid = 1'b0; a = '0; b = '0; ci = 1'b0;
      end
      #1;
      expReady = !(occ == 2 && !out_ready);
      checks++;
      if (in_ready !== expReady) begin
        errors++;
        $display("[TB] FAIL b2b_in_ready cycle %0d got %0b expected %0b", cyc, in_ready, expReady);
      end
      if (prevStall) begin
        checks++;
        if ({out_valid, s, co, overflow} !== {1'b1, prevS, prevCo, prevOv}) begin
          errors++;
          $display("[TB] FAIL b2b_hold cycle %0d got v=%0b s=%h co=%0b ov=%0b expected v=1 s=%h co=%0b ov=%0b",
                   cyc, out_valid, s, co, overflow, prevS, prevCo, prevOv);
        end
      end
      fireIn  = in_valid && in_ready;
      fireOut = out_valid && out_ready;
      if (fireOut) begin
        checks++;
        if ({s, co, overflow} !== {xs[recv], xc[recv], xo[recv]}) begin
          errors++;
          $display("[TB] FAIL b2b_result%0d got s=%h co=%0b ov=%0b expected s=%h co=%0b ov=%0b",
                   recv, s, co, overflow, xs[recv], xc[recv], xo[recv]);
        end
        recv++;
      end
      if (fireIn) sent++;
      occ = occ + int'(fireIn) - int'(fireOut);
      prevStall = out_valid && !out_ready;
      prevS = s; prevCo = co; prevOv = overflow;
      @(posedge clock); #1;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++;
    if (recv !== 8) begin
      errors++;
      $display("[TB] FAIL b2b_count got %0d results expected 8", recv);
    end
    repeat (2) @(posedge clock); #1;
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; a = 32'd1; b = 32'd2; ci = 1'b0;
    @(posedge clock); #1;
    a = 32'd3; b = 32'd4;
    @(posedge clock); #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midrst_full got %0b expected 1", out_valid);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({out_valid, s, co, overflow} !== 35'd0) begin
      errors++;
      $display("[TB] FAIL midrst_clear got v=%0b s=%h co=%0b ov=%0b expected all zero",
               out_valid, s, co, overflow);
    end
    in_valid = 1'b1; a = 32'd5; b = 32'd6;
    @(posedge clock); #1;
    in_valid = 1'b0; a = '0; b = '0;
    reset = 1'b0; out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midrst_in_ready got %0b expected 1", in_ready);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL midrst_ghost cycle %0d got %0b expected 0", i, out_valid);
      end
    end
  endtask

`ifdef CSA_SUB_EN
  task automatic test_sub();
    logic [31:0] ta [3] = '{32'h80000000, 32'h00000005, 32'h00000000};
    logic [31:0] tb [3] = '{32'h00000001, 32'h00000003, 32'h00000001};
    logic        tc [3] = '{1'b0, 1'b1, 1'b0};
    logic [31:0] es [3] = '{32'h7FFFFFFF, 32'h00000002, 32'hFFFFFFFF};
    logic        ec [3] = '{1'b1, 1'b1, 1'b0};
    logic        eo [3] = '{1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      a = ta[i]; b = tb[i]; ci = tc[i]; sub = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clock); #1;
      in_valid = 1'b0; sub = 1'b0;
      @(posedge clock); #1;
      checks++;
      if ({out_valid, s, co, overflow} !== {1'b1, es[i], ec[i], eo[i]}) begin
        errors++;
        $display("[TB] FAIL sub%0d got v=%0b s=%h co=%0b ov=%0b expected v=1 s=%h co=%0b ov=%0b",
                 i, out_valid, s, co, overflow, es[i], ec[i], eo[i]);
      end
      @(posedge clock); #1;
    end
  endtask
`endif

  task automatic test_random16();
    logic [17:0] expQ [$];
    logic [17:0] got, want;
    logic [15:0] ms;
    logic        mc, mo, fireIn, fireOut;
    int          sent, recv, cyc;
    sent = 0; recv = 0; cyc = 0;
    while (recv < 1000 && cyc < 20000) begin
      outReady16 = 1'($urandom_range(0, 1));
      if (sent < 1000) begin
        inValid16 = ($urandom_range(0, 3) != 0);
        a16 = 16'($urandom); b16 = 16'($urandom); ci16 = 1'($urandom_range(0, 1));
      end else begin
        inValid16 = 1'b0;
      end
      #1;
      fireIn  = inValid16 && inReady16;
      fireOut = outValid16 && outReady16;
      if (fireOut) begin
        checks++;
        got = {overflow16, co16, s16};
        if (expQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL rnd_unexpected got s=%h with nothing outstanding", s16);
        end else begin
          want = expQ.pop_front();
          if (got !== want) begin
            errors++;
            $display("[TB] FAIL rnd_result%0d got ov/co/s=%h expected %h", recv, got, want);
          end
        end
        recv++;
      end
      if (fireIn) begin
        model16(a16, b16, ci16, ms, mc, mo);
        expQ.push_back({mo, mc, ms});
        sent++;
      end
      @(posedge clock); #1;
      cyc++;
    end
    inValid16 = 1'b0;
    checks++;
    if (recv !== 1000 || expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL rnd_count got %0d results, %0d pending, expected 1000 and 0",
               recv, expQ.size());
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_mid_reset();
`ifdef CSA_SUB_EN
    test_sub();
`endif
    test_random16();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
